// File: rtl/calc_seq_fsm.sv
// calc_seq_fsm: sequential switch/button calculator.
// Operands A and B are entered one after another on SW and confirmed with a
// debounced ENTER button; a one-hot operation button registers the result R.
// dsp_num feeds the 8-digit 7-segment driver.
// Optional feature macro: CALC_CHAIN_EN (ENTER in S_RES chains R into A
// instead of clearing everything).
module calc_seq_fsm #(
  parameter int N               = 8,       // operand width, 1..16
  parameter int DEBOUNCE_CYCLES = 1000000  // stable-high cycles per press, >= 2
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [N-1:0] SW,
  input  logic         BTN_ENTER,
  input  logic [3:0]   BTN,
  output logic [31:0]  dsp_num,
  output logic [1:0]   state_led,
  output logic         ovf
);

  localparam int NB = 5;  // ENTER + four op buttons
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1, sync2;
  logic [CW-1:0] cnt [NB];
  logic [NB-1:0] pulse;

  assign btn_raw = {BTN_ENTER, BTN};

  // Synchronise each button, count stable-high cycles, pulse once on arrival at the limit.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
      pulse <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (!sync2[i])             cnt[i] <= '0;
        else if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CW'(1);
        // Fires only on the single cycle the counter steps from MAX-1 to MAX;
        // saturation prevents repeats while held.
        pulse[i] <= sync2[i] && (cnt[i] == CNT_ARM);
      end
    end
  end

  logic       enter_pulse;
  logic [3:0] op_pulse;
  logic       op_valid;

  assign enter_pulse = pulse[4];
  assign op_pulse    = pulse[3:0];
  assign op_valid    = $onehot(op_pulse);  // simultaneous ops are ignored

  // ---------------------------------------------------------------------------
  // Datapath registers and FSM
  // ---------------------------------------------------------------------------
  state_t       state, next_state;
  logic [N-1:0] a, b, next_a, next_b;
  logic [N:0]   r, next_r;
  logic         next_ovf;
  logic [N:0]   alu_r;
  logic         alu_ovf;
  logic [31:0]  next_dsp;

  // ALU: result for whichever single op button is pulsing.
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    if (op_pulse[0]) begin
      alu_r   = {1'b0, a} + {1'b0, b};
      alu_ovf = alu_r[N];
    end else if (op_pulse[1]) begin
      alu_r   = {1'b0, a} - {1'b0, b};
      alu_ovf = (a < b);
    end else if (op_pulse[2]) begin
      alu_r   = {1'b0, a & b};
    end else if (op_pulse[3]) begin
      alu_r   = {1'b0, a | b};
    end
  end

  // Next-state and next-operand logic; the pulse relevant to the current state wins.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_a     = a;
    next_b     = b;
    next_r     = r;
    next_ovf   = ovf;
    case (state)
      S_A: if (enter_pulse) begin
        next_a     = SW;
        next_state = S_B;
      end
      S_B: if (enter_pulse) begin
        next_b     = SW;
        next_state = S_OP;
      end
      S_OP: if (op_valid) begin
        next_r     = alu_r;
        next_ovf   = alu_ovf;
        next_state = S_RES;
      end
      S_RES: begin
        if (enter_pulse) begin
`ifdef CALC_CHAIN_EN
          // Chain: previous result becomes A, ovf held until the next result.
          next_a     = r[N-1:0];
          next_b     = '0;
          next_state = S_B;
`else
          next_a     = '0;
          next_b     = '0;
          next_r     = '0;
          next_ovf   = 1'b0;
          next_state = S_A;
`endif
        end else if (op_valid) begin
          next_r   = alu_r;
          next_ovf = alu_ovf;
        end
      end
      default: next_state = S_A;
    endcase
  end

  // Display word from the current (registered) state, operands and live switches.
  always_comb begin
    next_dsp = '0;
    case (state)
      S_A, S_B: next_dsp = 32'(SW);
      S_OP:     next_dsp = {16'(a), 16'(b)};
      S_RES:    next_dsp = 32'(r);
      default:  next_dsp = '0;
    endcase
  end

  // State, operand, result and display registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state   <= S_A;
      a       <= '0;
      b       <= '0;
      r       <= '0;
      ovf     <= 1'b0;
      dsp_num <= '0;
    end else begin
      state   <= next_state;
      a       <= next_a;
      b       <= next_b;
      r       <= next_r;
      ovf     <= next_ovf;
      dsp_num <= next_dsp;
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_calc_seq_fsm.sv
// Self-checking bench for calc_seq_fsm (N=8, DEBOUNCE_CYCLES=4).
// A behavioural model predicts state/display/ovf per button action; the
// expectation is queued when the action is driven and compared after it settles.
module tb_calc_seq_fsm;

  localparam int N  = 8;
  localparam int DB = 4;

  logic         CLK100MHZ;
  logic         CPU_RESETN;
  logic [N-1:0] SW;
  logic         BTN_ENTER;
  logic [3:0]   BTN;
  logic [31:0]  dsp_num;
  logic [1:0]   state_led;
  logic         ovf;

  calc_seq_fsm #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .SW        (SW),
    .BTN_ENTER (BTN_ENTER),
    .BTN       (BTN),
    .dsp_num   (dsp_num),
    .state_led (state_led),
    .ovf       (ovf)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] dsp;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model
  int m_st, m_a, m_b, m_r, m_ovf, m_sw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_ovf = 0;
  endtask

  task automatic model_enter();
    case (m_st)
      0: begin m_a = m_sw; m_st = 1; end
      1: begin m_b = m_sw; m_st = 2; end
      3: begin
`ifdef CALC_CHAIN_EN
        m_a = m_r % 256; m_b = 0; m_st = 1;
`else
        m_a = 0; m_b = 0; m_r = 0; m_ovf = 0; m_st = 0;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic model_op(input logic [3:0] ops);
    if ($countones(ops) == 1 && (m_st == 2 || m_st == 3)) begin
      case (ops)
        4'b0001: begin m_r = m_a + m_b; m_ovf = (m_r > 255) ? 1 : 0; end
        4'b0010: begin
          if (m_a >= m_b) begin m_r = m_a - m_b; m_ovf = 0; end
          else            begin m_r = 512 + m_a - m_b; m_ovf = 1; end
        end
        4'b0100: begin m_r = m_a & m_b; m_ovf = 0; end
        default: begin m_r = m_a | m_b; m_ovf = 0; end
      endcase
      m_st = 3;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.st  = 2'(m_st);
    e.ovf = 1'(m_ovf);
    case (m_st)
      0, 1:    e.dsp = 32'(m_sw);
      2:       e.dsp = (32'(m_a) << 16) | 32'(m_b);
      default: e.dsp = 32'(m_r);
    endcase
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_state"}, 32'(state_led), 32'(e.st));
    check({tag, "_dsp"},   dsp_num,        e.dsp);
    check({tag, "_ovf"},   32'(ovf),       32'(e.ovf));
  endtask

  // Hold buttons for 'hold' cycles, release, then let the pipeline settle.
  task automatic press(input logic ent, input logic [3:0] ops, input int hold);
    @(negedge CLK100MHZ);
    BTN_ENTER = ent;
    BTN       = ops;
    repeat (hold) @(negedge CLK100MHZ);
    BTN_ENTER = 1'b0;
    BTN       = 4'b0;
    repeat (8) @(negedge CLK100MHZ);
  endtask

  // One full button action: set switches, predict, drive, compare.
  task automatic step(input string tag, input logic [7:0] sw, input logic ent, input logic [3:0] ops);
    @(negedge CLK100MHZ);
    SW   = sw;
    m_sw = int'(sw);
    if (ent && m_st != 2) model_enter();
    else                  model_op(ops);
    push_expected();
    press(ent, ops, 10);
    pop_compare(tag);
  endtask

  task automatic do_reset(input logic [7:0] sw);
    @(negedge CLK100MHZ);
    SW         = sw;
    m_sw       = int'(sw);
    BTN_ENTER  = 1'b0;
    BTN        = 4'b0;
    CPU_RESETN = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    push_expected();
    @(negedge CLK100MHZ);
    pop_compare("reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    SW         = '0;
    BTN_ENTER  = 1'b0;
    BTN        = 4'b0;
    CPU_RESETN = 1'b1;
    model_reset();

    // Reset with all switches high: display shows SW one cycle after release.
    do_reset(8'hFF);

    // Glitch shorter than the debounce window: no transition.
    @(negedge CLK100MHZ);
    SW = 8'h33; m_sw = 8'h33;
    push_expected();
    press(1'b1, 4'b0, 3);
    pop_compare("glitch");

    // Real press: measure press-to-state latency (2 + DB + 1 cycles).
    @(negedge CLK100MHZ);
    BTN_ENTER = 1'b1;
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK100MHZ);
      if (state_led == 2'd1) begin
        lat = i;
        break;
      end
    end
    check("enter_latency", 32'(lat), 32'(DB + 3));
    repeat (4) @(negedge CLK100MHZ);
    BTN_ENTER = 1'b0;
    repeat (8) @(negedge CLK100MHZ);
    model_enter();
    push_expected();
    pop_compare("enter_once");
    // B entry then S_OP shows {A,B}: confirms A captured 0x33.
    step("capture_a", 8'h44, 1'b1, 4'b0);

    // ADD with carry, with an illegal double op and an ignored ENTER first.
    do_reset(8'd0);
    step("add_a",      8'd200, 1'b1, 4'b0);
    step("add_b",      8'd100, 1'b1, 4'b0);
    step("illegal_op", 8'd0,   1'b0, 4'b1001);
    step("op_enter",   8'd9,   1'b1, 4'b0);
    step("add",        8'd0,   1'b0, 4'b0001);

    // SUB with borrow (ENTER pressed together with SUB in S_OP: op wins),
    // then AND recomputed in S_RES, then OR.
    do_reset(8'd0);
    step("sub_a",  8'd5, 1'b1, 4'b0);
    step("sub_b",  8'd7, 1'b1, 4'b0);
    step("sub",    8'd0, 1'b1, 4'b0010);
    step("and_re", 8'd0, 1'b0, 4'b0100);
    step("or_re",  8'd0, 1'b0, 4'b1000);

    // Chain / clear behaviour of ENTER in S_RES.
    do_reset(8'd0);
    step("ch_a",     8'd10, 1'b1, 4'b0);
    step("ch_b",     8'd20, 1'b1, 4'b0);
    step("ch_add",   8'd0,  1'b0, 4'b0001);
    step("ch_enter", 8'd0,  1'b1, 4'b0);
    step("ch_next",  8'd5,  1'b1, 4'b0);
    step("ch_sub",   8'd0,  1'b0, 4'b0010);
    step("ch_more",  8'd3,  1'b1, 4'b0);
    step("ch_final", 8'd0,  1'b0, 4'b0001);

    // Reset mid-debounce discards the partial press.
    @(negedge CLK100MHZ);
    BTN_ENTER = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    BTN_ENTER = 1'b0;
    do_reset(8'h5A);
    @(negedge CLK100MHZ);
    push_expected();
    press(1'b0, 4'b0, 1);
    pop_compare("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
